transit_rr_sched: RTL
=====================

# transit_rr_sched

Round-robin scheduler that shares a single two-phase transit engine between N requesters. The engine takes a `do` level input and returns per-cycle `s` (step) and end-of-run `g` (go/done) pulses. The scheduler grants one requester at a time and holds `eng_do` for exactly the requested number of steps. It confirms the engine's `g` completion pulse, returns a `done` pulse to the winner, and flags protocol errors. It sits between the requester ports and the engine instance in the datapath.

## Interface

- N, 4: number of requesters (2..8)
- LW, 4: width of each per-requester step count
- TMO, 3: max cycles in WAITG before timeout error
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N  request level per requester; must hold until its grant bit rises
- len  in  N*LW  step count, requester i at bits [i*LW +: LW]; 0 treated as 1
- grant  out  N  one-hot grant, registered
- done  out  N  one-cycle completion pulse to the granted requester
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle protocol error pulse
- eng_do  out  1  level to the engine, registered
- eng_s  in  1  engine step pulse (one per step)
- eng_g  in  1  engine completion pulse (after eng_do falls)

## Operation

- States: IDLE, RUN, WAITG, GAP.
- Reset values: state IDLE, grant 0, done 0, busy 0, err 0, eng_do 0, cnt 0, ptr N-1. These take effect immediately on rst_n low, including mid-burst.
- IDLE, any req set:
  - Winner is the first set req searching ptr+1, ptr+2, … mod N.
  - grant <= onehot(winner); ptr <= winner.
  - cnt <= max(len[winner], 1); eng_do <= 1; go to RUN.
- RUN: each cycle with eng_s=1 decrements cnt. When eng_s=1 and cnt==1: eng_do <= 0, go to WAITG.
- RUN, eng_g=1 (premature): err pulse, eng_do <= 0, grant <= 0, go to GAP, no done.
- WAITG, eng_g=1: done <= grant, grant <= 0, go to GAP.
- WAITG, TMO cycles elapsed without eng_g: err pulse, grant <= 0, go to IDLE, no done.
- GAP: one cycle, to cover the engine's post-run state. done is high during this cycle. Always go to IDLE.
- len and req of the winner are sampled only at grant. Later changes have no effect on the current burst.
- A req from the current winner during its own burst is not serviced until the next arbitration.
- Other requesters' req inputs are ignored outside IDLE.
- The LW-bit counter never wraps: it is loaded at ≥1 and stops at 1.

## Timing

- Grant at edge E0 gives the following cycle sequence for step count L:
  - C1: grant and eng_do high; engine enters its run state.
  - C2..C(L+1): eng_s high; eng_do still high.
  - C(L+2): eng_do low, eng_g high.
  - C(L+3): GAP, done high.
  - C(L+4): IDLE, ready to arbitrate.
- grant is high for L+2 cycles.
- Back-to-back throughput is L+4 cycles per burst, and eng_do is low for ≥3 cycles between bursts.
- Arbitration latency from req rise in IDLE to grant is 1 cycle.
- err and done are never high in the same cycle.

## Test plan

- Single requester: req[2]=1, len=3 -> grant=0100 for 5 cycles, eng_do high 4 cycles, exactly 3 eng_s, done[2] one cycle in the GAP cycle, busy low 1 cycle later.
- Round-robin: req=1111 held, all len=1 -> grant order 0001, 0010, 0100, 1000, 0001, with a 5-cycle period per grant.
- len=0 on requester 1 -> behaves as len=1: one eng_s, done[1] pulse.
- Max len=15 -> counter counts 15 steps without wrap, eng_do high 16 cycles.
- Engine model withholds eng_g -> err pulse exactly TMO=3 cycles after entering WAITG; no done; scheduler in IDLE and granting the next requester.
- rst_n low during RUN with len=8 -> eng_do, grant, busy drop asynchronously. After release, req=0001 is granted first, since ptr was reset to N-1.

Source files
------------

// File: rtl/transit_rr_sched_if.sv
// rtl/transit_rr_sched_if.sv - requester and engine handshake bundle for transit_rr_sched
interface transit_rr_sched_if #(
  parameter int N  = 4,
  parameter int LW = 4
);
  logic [N-1:0]    req;
  logic [N*LW-1:0] len;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic            err;
  logic            eng_do;
  logic            eng_s;
  logic            eng_g;

  modport slave (
    input  req, len, eng_s, eng_g,
    output grant, done, busy, err, eng_do
  );

  modport master (
    output req, len, eng_s, eng_g,
    input  grant, done, busy, err, eng_do
  );
endinterface

// File: rtl/transit_rr_sched.sv
// rtl/transit_rr_sched.sv - round-robin scheduler sharing one two-phase transit engine
module transit_rr_sched #(
  parameter int N   = 4,
  parameter int LW  = 4,
  parameter int TMO = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  transit_rr_sched_if.slave  bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, RUN, WAITG, GAP} state_t;

  state_t          state, state_nx;
  logic [N-1:0]    grant_q, grant_nx;
  logic [N-1:0]    done_q, done_nx;
  logic            err_q, err_nx;
  logic            do_q, do_nx;
  logic [LW-1:0]   cnt, cnt_nx;
  logic [PW-1:0]   ptr, ptr_nx;
  logic [TW-1:0]   tmr, tmr_nx;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic [LW-1:0]   lsel;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    lsel = bus.len[win*LW +: LW];
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant_q;
    done_nx  = '0;
    err_nx   = 1'b0;
    do_nx    = do_q;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    tmr_nx   = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_nx = N'(1) << win;
          ptr_nx   = win;
          cnt_nx   = (lsel == '0) ? LW'(1) : lsel;
          do_nx    = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (bus.eng_g) begin
          // Completion before the steps were delivered: abandon the burst.
          err_nx   = 1'b1;
          do_nx    = 1'b0;
          grant_nx = '0;
          state_nx = GAP;
        end else if (bus.eng_s) begin
          if (cnt <= LW'(1)) begin
            do_nx    = 1'b0;
            state_nx = WAITG;
          end else begin
            cnt_nx = cnt - LW'(1);
          end
        end
      end
      WAITG: begin
        if (bus.eng_g) begin
          done_nx  = grant_q;
          grant_nx = '0;
          state_nx = GAP;
        end else if (tmr == TW'(TMO - 1)) begin
          err_nx   = 1'b1;
          grant_nx = '0;
          state_nx = IDLE;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      do_q    <= 1'b0;
      cnt     <= '0;
      ptr     <= PW'(N - 1);
      tmr     <= '0;
    end else begin
      state   <= state_nx;
      grant_q <= grant_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
      do_q    <= do_nx;
      cnt     <= cnt_nx;
      ptr     <= ptr_nx;
      tmr     <= tmr_nx;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.eng_do = do_q;
  assign bus.busy   = (state != IDLE);
endmodule
